// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter time-sharing one combinational ALU among NREQ requesters.
// Define ALU_ARB_LOCAL_ZERO_EN to derive the zero flag locally from alu_result.
module alu_share_arbiter #(
  parameter int NREQ = 2,
  parameter int W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ*4-1:0] req_op,
  output logic [NREQ-1:0]   rsp_valid,
  input  logic [NREQ-1:0]   rsp_ready,
  output logic [W-1:0]      rsp_result,
  output logic              rsp_zero,
  output logic [W-1:0]      alu_data1,
  output logic [W-1:0]      alu_data2,
  output logic [3:0]        alu_control,
  input  logic [W-1:0]      alu_result,
  input  logic              alu_zero
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] owner;
  logic [PW-1:0] win;
  logic          found;
  logic          zero_in;

  function automatic logic [PW-1:0] wrap(
    input logic [PW-1:0] p,
    input int            k
  );
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return PW'(s);
  endfunction

  function automatic logic [NREQ-1:0] onehot(
    input logic [PW-1:0] i
  );
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

`ifdef ALU_ARB_LOCAL_ZERO_EN
  logic unused_zero;
  assign unused_zero = alu_zero;
  assign zero_in     = (alu_result == '0);
`else
  assign zero_in = alu_zero;
`endif

  // Winner search: first valid requester at or after ptr, wrapping.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[wrap(ptr, k)]) begin
        win   = wrap(ptr, k);
        found = 1'b1;
      end
    end
  end

  // Accept strobe only to the winner, only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (rst_n && state == IDLE && found) req_ready[win] = 1'b1;
  end

  // Control FSM with registered ALU operands and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      alu_data1   <= '0;
      alu_data2   <= '0;
      alu_control <= 4'b0000;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_valid   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            alu_data1   <= req_a[int'(win)*W +: W];
            alu_data2   <= req_b[int'(win)*W +: W];
            alu_control <= req_op[int'(win)*4 +: 4];
            owner       <= win;
            ptr         <= wrap(win, 1);
            state       <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= zero_in;
          rsp_valid  <= onehot(owner);
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter that time-shares the single combinational ALU (AND/OR/ADD/SUB via 4-bit control) between NREQ requesters. It sits between the requesters and the ALU's data1/data2/ALU_control inputs and its result/Zero outputs. It accepts one operation at a time over a valid/ready handshake, registers the operands into the ALU, and captures the result. The result is returned to the owning requester over a valid/ready response channel.

## Interface
- NREQ, 2, number of requesters (2..8)
- W, 32, operand/result width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester operation request
- req_ready  out  NREQ  one-hot accept strobe
- req_a  in  NREQ*W  operand A, slice i = [i*W +: W]
- req_b  in  NREQ*W  operand B, same slicing
- req_op  in  NREQ*4  ALU control, slice i = [i*4 +: 4]
- rsp_valid  out  NREQ  one-hot result valid to owner
- rsp_ready  in  NREQ  per-requester result accept
- rsp_result  out  W  shared result bus, meaningful only where rsp_valid set
- rsp_zero  out  1  zero flag accompanying rsp_result
- alu_data1  out  W  to ALU data1
- alu_data2  out  W  to ALU data2
- alu_control  out  4  to ALU ALU_control
- alu_result  in  W  from ALU
- alu_zero  in  1  from ALU Zero

## Operation
- FSM states IDLE, EXEC, RESP. Reset state IDLE.
- IDLE:
  - Winner = first i with req_valid[i], searching from ptr upward, wrapping modulo NREQ.
  - req_ready[winner]=1 combinationally; all other req_ready bits are 0.
  - On accept: capture winner's a/b/op into alu_data1/alu_data2/alu_control, latch owner=winner, ptr=(winner+1) mod NREQ, go to EXEC.
  - No valid request: stay in IDLE, ptr unchanged.
- EXEC: ALU inputs are stable for the full cycle. At the clock edge, capture alu_result into rsp_result and the zero flag into rsp_zero, then go to RESP.
- RESP:
  - rsp_valid[owner]=1.
  - When rsp_ready[owner]=1, the handshake completes and the FSM returns to IDLE.
  - rsp_ready of non-owners is ignored.
- req_ready is 0 in EXEC and RESP.
- alu_data1/alu_data2/alu_control hold their last captured values outside EXEC.
- rsp_result/rsp_zero hold until the next EXEC capture.
- Requester rules (not checked by the arbiter):
  - Once req_valid is asserted, it stays asserted with a stable payload until req_ready.
  - A requester has at most one outstanding operation.
- Unsupported op codes (anything other than 0000, 0001, 0010, 0110) are forwarded unchanged; the result is whatever the ALU returns (0 for the current ALU).
- Reset values:
  - req_ready=0, rsp_valid=0, rsp_result=0, rsp_zero=0.
  - alu_data1=0, alu_data2=0, alu_control=4'b0000.
  - ptr=0, owner=0.
- Reset asserted in any state: return to IDLE immediately. An in-flight operation is dropped with no response.

## Timing
- Accept in cycle T; EXEC in T+1; rsp_valid high from T+2.
- If rsp_ready is high at T+2, the FSM is in IDLE at T+3, and the earliest next accept is T+3. Peak throughput is 1 op / 3 cycles.
- Backpressure: RESP holds indefinitely. rsp_valid, rsp_result and rsp_zero stay stable and no new request is accepted.
- Continuous valid on all requesters gives strict rotation 0,1,…,NREQ-1,0. A request waits at most NREQ-1 operations.
- Simultaneous new req_valid during RESP is seen only in IDLE. Arbitration uses req_valid at the IDLE cycle only.
- No combinational path from alu_result/alu_zero to any output.

## Configuration
- ALU_ARB_LOCAL_ZERO_EN
  - Defined: rsp_zero is captured as (alu_result == 0) computed inside the arbiter; alu_zero is ignored.
  - Undefined: rsp_zero is captured directly from alu_zero.

## Test plan
- Reset release, req_valid[0] with a=5, b=7, op=0010 at T → req_ready[0] at T, rsp_valid[0] at T+2, rsp_result=12. rsp_ready[0]=1 then IDLE at T+3.
- req_valid[0] and req_valid[1] both held with different ops (0: 0110 a=20 b=3; 1: 0000 a=0xF0 b=0x3C) → order 0,1,0,1. Results 17 and 0x30 (bitwise AND) return to the correct owner only.
- op=0110 a=9 b=9 → result 0. rsp_zero=1 with ALU_ARB_LOCAL_ZERO_EN; rsp_zero=0 without the macro (current ALU drives Zero=0).
- rsp_ready[owner] low for 4 cycles in RESP with req_valid[1] high → rsp_valid and result stable, req_ready stays 0. req_ready[1] rises in the cycle after rsp_ready goes high.
- rst_n pulsed low during EXEC → all outputs return to reset values, no rsp_valid issued. Next request from requester 1 with requester 0 also valid → requester 0 granted first (ptr=0).
- op=1111 a=3 b=4 → rsp_valid at T+2 with rsp_result=0. FSM returns to IDLE normally.
